// File: rtl/crossbar_2x2_arbiter_if.sv
// Port bundle for the 2x2 crossbar arbiter front end.
// CROSSBAR_ARB_STATS_EN adds the conflict_cnt signal.
interface crossbar_2x2_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             in1_valid;
  logic             in2_valid;
  logic [WIDTH-1:0] in1_data;
  logic [WIDTH-1:0] in2_data;
  logic             in1_dest;
  logic             in2_dest;
  logic             in1_ready;
  logic             in2_ready;
  logic             out1_valid;
  logic             out2_valid;
  logic [WIDTH-1:0] out1_data;
  logic [WIDTH-1:0] out2_data;
  logic             out1_ready;
  logic             out2_ready;
  logic             control;
`ifdef CROSSBAR_ARB_STATS_EN
  logic [7:0]       conflict_cnt;

  modport slave (
    input  in1_valid, in2_valid,
    input  in1_data, in2_data,
    input  in1_dest, in2_dest,
    output in1_ready, in2_ready,
    output out1_valid, out2_valid,
    output out1_data, out2_data,
    input  out1_ready, out2_ready,
    output control,
    output conflict_cnt
  );

  modport master (
    output in1_valid, in2_valid,
    output in1_data, in2_data,
    output in1_dest, in2_dest,
    input  in1_ready, in2_ready,
    input  out1_valid, out2_valid,
    input  out1_data, out2_data,
    output out1_ready, out2_ready,
    input  control,
    input  conflict_cnt
  );
`else
  modport slave (
    input  in1_valid, in2_valid,
    input  in1_data, in2_data,
    input  in1_dest, in2_dest,
    output in1_ready, in2_ready,
    output out1_valid, out2_valid,
    output out1_data, out2_data,
    input  out1_ready, out2_ready,
    output control
  );

  modport master (
    output in1_valid, in2_valid,
    output in1_data, in2_data,
    output in1_dest, in2_dest,
    input  in1_ready, in2_ready,
    input  out1_valid, out2_valid,
    input  out1_data, out2_data,
    output out1_ready, out2_ready,
    input  control
  );
`endif
endinterface

// File: rtl/crossbar_2x2_arbiter.sv
// Registered round-robin front end for the 2x2 crossbar.
// CROSSBAR_ARB_STATS_EN adds a saturating contention counter.
module crossbar_2x2_arbiter #(
  parameter int WIDTH = 4
) (
  input logic                   clk,
  input logic                   rst,
  crossbar_2x2_arbiter_if.slave bus
);

  typedef enum logic {
    PRI_IN1,
    PRI_IN2
  } ptr_e;

  ptr_e             state_q;
  ptr_e             state_d;
  logic             free1;
  logic             free2;
  logic             tfree1;
  logic             tfree2;
  logic             contend;
  logic             grant1;
  logic             grant2;
  logic             load1;
  logic             load2;
  logic [WIDTH-1:0] data1_d;
  logic [WIDTH-1:0] data2_d;
  logic             ctl_d;
  logic             ctl_q;
  logic             o1_v_q;
  logic             o2_v_q;
  logic [WIDTH-1:0] o1_d_q;
  logic [WIDTH-1:0] o2_d_q;

  // Grant resolution and next pointer state
  always_comb begin
    state_d = state_q;
    grant1  = 1'b0;
    grant2  = 1'b0;
    free1   = !o1_v_q || bus.out1_ready;
    free2   = !o2_v_q || bus.out2_ready;
    tfree1  = bus.in1_dest ? free2 : free1;
    tfree2  = bus.in2_dest ? free2 : free1;
    contend = !rst && bus.in1_valid
            && bus.in2_valid
            && (bus.in1_dest == bus.in2_dest)
            && tfree1;
    if (!rst) begin
      grant1 = bus.in1_valid && tfree1
             && (!contend || state_q == PRI_IN1);
      grant2 = bus.in2_valid && tfree2
             && (!contend || state_q == PRI_IN2);
    end
    if (contend) begin
      state_d = (state_q == PRI_IN1) ? PRI_IN2 : PRI_IN1;
    end
  end

  // Per-output load select and next crossbar setting
  always_comb begin
    load1   = (grant1 && !bus.in1_dest)
            || (grant2 && !bus.in2_dest);
    load2   = (grant1 && bus.in1_dest)
            || (grant2 && bus.in2_dest);
    data1_d = (grant1 && !bus.in1_dest)
            ? bus.in1_data : bus.in2_data;
    data2_d = (grant1 && bus.in1_dest)
            ? bus.in1_data : bus.in2_data;
    ctl_d   = ctl_q;
    priority case (1'b1)
      grant1:  ctl_d = bus.in1_dest;
      grant2:  ctl_d = ~bus.in2_dest;
      default: ctl_d = ctl_q;
    endcase
  end

  // Pointer state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= PRI_IN1;
    else     state_q <= state_d;
  end

  // Output holding registers and control
  always_ff @(posedge clk) begin
    if (rst) begin
      o1_v_q <= 1'b0;
      o2_v_q <= 1'b0;
      o1_d_q <= '0;
      o2_d_q <= '0;
      ctl_q  <= 1'b0;
    end else begin
      ctl_q <= ctl_d;
      if (load1) begin
        o1_v_q <= 1'b1;
        o1_d_q <= data1_d;
      end else if (bus.out1_ready) begin
        o1_v_q <= 1'b0;
      end
      if (load2) begin
        o2_v_q <= 1'b1;
        o2_d_q <= data2_d;
      end else if (bus.out2_ready) begin
        o2_v_q <= 1'b0;
      end
    end
  end

`ifdef CROSSBAR_ARB_STATS_EN
  logic [7:0] cnt_q;

  // Saturating count of contention cycles
  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= 8'd0;
    else if (contend && cnt_q != 8'hFF)
      cnt_q <= cnt_q + 8'd1;
  end

  assign bus.conflict_cnt = cnt_q;
`endif

  assign bus.in1_ready  = grant1;
  assign bus.in2_ready  = grant2;
  assign bus.out1_valid = o1_v_q;
  assign bus.out2_valid = o2_v_q;
  assign bus.out1_data  = o1_d_q;
  assign bus.out2_data  = o2_d_q;
  assign bus.control    = ctl_q;

endmodule

// File: tb/tb_crossbar_2x2_arbiter.sv
// Directed vector bench for crossbar_2x2_arbiter.
// Define CROSSBAR_ARB_STATS_EN to also check conflict_cnt.
module tb_crossbar_2x2_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  crossbar_2x2_arbiter_if #(.WIDTH(4)) bus ();

  crossbar_2x2_arbiter #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic       v1;
    logic [3:0] d1;
    logic       t1;
    logic       v2;
    logic [3:0] d2;
    logic       t2;
    logic       or1;
    logic       or2;
    logic       er1;
    logic       er2;
    logic       eo1v;
    logic [3:0] eo1d;
    logic       eo2v;
    logic [3:0] eo2d;
    logic       ectl;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic v1, input logic [3:0] d1,
    input logic t1,
    input logic v2, input logic [3:0] d2,
    input logic t2,
    input logic or1, input logic or2,
    input logic er1, input logic er2,
    input logic eo1v, input logic [3:0] eo1d,
    input logic eo2v, input logic [3:0] eo2d,
    input logic ectl);
    vec_t v;
    v.v1 = v1; v.d1 = d1; v.t1 = t1;
    v.v2 = v2; v.d2 = d2; v.t2 = t2;
    v.or1 = or1; v.or2 = or2;
    v.er1 = er1; v.er2 = er2;
    v.eo1v = eo1v; v.eo1d = eo1d;
    v.eo2v = eo2v; v.eo2d = eo2d;
    v.ectl = ectl;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.in1_valid  = v.v1;
    bus.in1_data   = v.d1;
    bus.in1_dest   = v.t1;
    bus.in2_valid  = v.v2;
    bus.in2_data   = v.d2;
    bus.in2_dest   = v.t2;
    bus.out1_ready = v.or1;
    bus.out2_ready = v.or2;
  endtask

  task automatic check_out(input string tag,
                           input vec_t v);
    chk({tag, " out1_valid"},
        int'(bus.out1_valid), int'(v.eo1v));
    chk({tag, " out1_data"},
        int'(bus.out1_data), int'(v.eo1d));
    chk({tag, " out2_valid"},
        int'(bus.out2_valid), int'(v.eo2v));
    chk({tag, " out2_data"},
        int'(bus.out2_data), int'(v.eo2d));
    chk({tag, " control"},
        int'(bus.control), int'(v.ectl));
  endtask

  task automatic step(input string tag,
                      input vec_t v);
    drive(v);
    #1;
    chk({tag, " in1_ready"},
        int'(bus.in1_ready), int'(v.er1));
    chk({tag, " in2_ready"},
        int'(bus.in2_ready), int'(v.er2));
    @(posedge clk);
    #1;
    check_out(tag, v);
  endtask

  vec_t tbl[16];
  vec_t v;

  initial begin
    // v1 d1 t1 v2 d2 t2 or1 or2 | r1 r2 o1v o1d o2v o2d ctl
    tbl[0]  = mk(1,4'hA,0, 1,4'h5,1, 1,1, 1,1, 1,4'hA,1,4'h5,0);
    tbl[1]  = mk(1,4'h3,1, 1,4'hC,0, 1,1, 1,1, 1,4'hC,1,4'h3,1);
    tbl[2]  = mk(1,4'h1,0, 1,4'h2,0, 1,1, 1,0, 1,4'h1,0,4'h3,0);
    tbl[3]  = mk(1,4'h1,0, 1,4'h2,0, 1,1, 0,1, 1,4'h2,0,4'h3,1);
    tbl[4]  = mk(1,4'h1,0, 1,4'h2,0, 1,1, 1,0, 1,4'h1,0,4'h3,0);
    tbl[5]  = mk(1,4'h1,0, 1,4'h2,0, 1,1, 0,1, 1,4'h2,0,4'h3,1);
    tbl[6]  = mk(1,4'h7,0, 0,4'h0,0, 1,1, 1,0, 1,4'h7,0,4'h3,0);
    tbl[7]  = mk(1,4'h9,0, 0,4'h0,0, 0,1, 0,0, 1,4'h7,0,4'h3,0);
    tbl[8]  = mk(1,4'h9,0, 0,4'h0,0, 0,1, 0,0, 1,4'h7,0,4'h3,0);
    tbl[9]  = mk(1,4'h9,0, 0,4'h0,0, 1,1, 1,0, 1,4'h9,0,4'h3,0);
    tbl[10] = mk(1,4'h4,0, 1,4'h6,0, 0,1, 0,0, 1,4'h9,0,4'h3,0);
    tbl[11] = mk(1,4'h4,0, 1,4'h6,0, 1,1, 1,0, 1,4'h4,0,4'h3,0);
    tbl[12] = mk(0,4'h0,0, 1,4'hB,1, 1,1, 0,1, 0,4'h4,1,4'hB,0);
    tbl[13] = mk(1,4'h8,1, 1,4'hD,1, 1,1, 0,1, 0,4'h4,1,4'hD,0);
    tbl[14] = mk(1,4'h1,0, 1,4'h2,0, 1,1, 1,0, 1,4'h1,0,4'hD,0);
    tbl[15] = mk(1,4'hE,1, 1,4'hF,0, 1,1, 1,1, 1,4'hF,1,4'hE,1);

    // Reset with traffic offered: no grants, cleared state
    v = mk(1,4'hA,0, 1,4'h5,1, 1,1, 0,0, 0,4'h0,0,4'h0,0);
    rst = 1'b1;
    step("rst0", v);
    step("rst1", v);
`ifdef CROSSBAR_ARB_STATS_EN
    chk("rst cnt", int'(bus.conflict_cnt), 0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      step($sformatf("vec%0d", i), tbl[i]);
`ifdef CROSSBAR_ARB_STATS_EN
      if (i == 5)
        chk("rr cnt", int'(bus.conflict_cnt), 4);
`endif
    end
`ifdef CROSSBAR_ARB_STATS_EN
    chk("pre-rst cnt", int'(bus.conflict_cnt), 7);
`endif

    // Mid-stream reset: both outputs full, pointer at PRI_IN2
    rst = 1'b1;
    v = mk(1,4'h1,0, 1,4'h2,0, 0,0, 0,0, 0,4'h0,0,4'h0,0);
    step("midrst", v);
`ifdef CROSSBAR_ARB_STATS_EN
    chk("midrst cnt", int'(bus.conflict_cnt), 0);
`endif
    rst = 1'b0;

    // First contention after reset goes to in1
    v = mk(1,4'h1,0, 1,4'h2,0, 1,1, 1,0, 1,4'h1,0,4'h0,0);
    step("postrst", v);
    v = mk(1,4'h1,0, 1,4'h2,0, 1,1, 0,1, 1,4'h2,0,4'h0,1);
    step("postrst2", v);

`ifdef CROSSBAR_ARB_STATS_EN
    chk("postrst cnt", int'(bus.conflict_cnt), 2);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (i == 99)
        chk("cnt mid", int'(bus.conflict_cnt), 102);
    end
    chk("cnt sat", int'(bus.conflict_cnt), 255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/crossbar_2x2_arbiter.md
# crossbar_2x2_arbiter

Sequenced, registered front end for the 2x2 4-bit crossbar datapath. Accepts 4-bit words from two valid/ready input ports, each tagged with a destination output. Resolves output contention with a round-robin pointer, drives the crossbar `control` setting, and holds each routed word in a per-output register until the downstream consumer takes it.

## Interface
- `WIDTH`, default 4: data width of every port.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `in1_valid`, `in2_valid`  input  1  word offered on the input port.
- `in1_data`, `in2_data`  input  WIDTH  offered word.
- `in1_dest`, `in2_dest`  input  1  destination: 0 = out1, 1 = out2.
- `in1_ready`, `in2_ready`  output  1  combinational grant; a transfer occurs when valid && ready.
- `out1_valid`, `out2_valid`  output  1  output register holds a word.
- `out1_data`, `out2_data`  output  WIDTH  registered word.
- `out1_ready`, `out2_ready`  input  1  consumer takes the word when valid && ready.
- `control`  output  1  registered crossbar setting of the last routing cycle: 0 = straight (in1→out1, in2→out2), 1 = cross (in1→out2, in2→out1).
- `conflict_cnt`  output  8  present only with `CROSSBAR_ARB_STATS_EN`.

## Operation
- Output k is free when `!outk_valid || outk_ready`.
- Requester i targets output `ini_dest`. It is granted iff `ini_valid`, the target is free, and it wins arbitration.
- No contention (different dests, or only one valid): every requester with a free target is granted.
- Contention (both valid, same dest, target free): the requester named by the pointer wins. The other gets ready = 0.
- Pointer FSM, two states:
  - PRI_IN1 (reset state): in1 wins contention.
  - PRI_IN2: in2 wins contention.
  - A state change happens only in a cycle where contention is resolved, and the state moves to favour the loser.
  - No contention, or target not free: state holds.
- Output register k loads the granted word and sets `outk_valid` = 1. Otherwise it clears `outk_valid` when `outk_ready`. Otherwise it holds (`outk_data` is stable while valid && !ready).
- Load and drain in the same cycle: the new word replaces the old one and valid stays 1. This gives full throughput, one word per output per cycle.
- `control` update on a transfer cycle:
  - Both granted: `control` = `in1_dest`.
  - Only in1 granted: `control` = `in1_dest`.
  - Only in2 granted: `control` = `~in2_dest`.
  - No grant: `control` holds.
- Ready is combinational and depends on valid, dest, state and out_ready. There are no combinational paths from ready to valid inside the block.

## Timing
- Latency: a word accepted at edge N is visible on `outk_valid`/`outk_data` after edge N. That is one cycle.
- `control` updates on the same edge as the corresponding output load.
- Reset values: `out1_valid` = `out2_valid` = 0, `out1_data` = `out2_data` = 0, `control` = 0, pointer = PRI_IN1, `conflict_cnt` = 0.
- Ready outputs are 0 whenever `rst` = 1.
- Reset mid-operation: held words are dropped at the reset edge and no transfer is accepted in that cycle.
- A blocked requester (target full and not draining) gets ready = 0 and does not change the pointer.

## Configuration
- `CROSSBAR_ARB_STATS_EN` defined:
  - `conflict_cnt` port exists.
  - It increments by 1 on every contention cycle (both valid, same dest, target free).
  - It saturates at 255 and is cleared by `rst`.
- Not defined: the port and counter are absent. Arbitration behaviour is identical.

## Test plan
- Straight routing: in1 = 4'hA dest 0, in2 = 4'h5 dest 1, both out_ready = 1 → both ready = 1. Next cycle out1 = A, out2 = 5, both valid, `control` = 0.
- Cross routing: in1 = 4'h3 dest 1, in2 = 4'hC dest 0 → next cycle out2 = 3, out1 = C, `control` = 1.
- Contention round-robin: both valid, dest 0, data in1 = 1, in2 = 2, held 4 cycles with out1_ready = 1 → out1 sequence 1, 2, 1, 2. The in2 flow gets out1 via `control` = 1. With stats enabled, `conflict_cnt` = 4.
- Back-pressure: out1_ready = 0 with out1 holding 4'h7, in1 = 4'h9 dest 0 → in1_ready = 0 and out1_data stays 7. Raising out1_ready gives in1_ready = 1, and out1 = 9 on the next cycle.
- Reset mid-stream: assert `rst` for one cycle while both outputs are valid → both valid = 0, data = 0, `control` = 0, pointer = PRI_IN1. The first contention afterwards is won by in1.
- Saturation (stats enabled): 300 contention cycles → `conflict_cnt` = 255.
